// File: rtl/sterownik_alu_wielobajtowy_pkg.sv
// Shared constants for the multi-byte ALU controller.
// The opcode codes match the external 8-bit ALU: DODAJ add, ODEJMIJ sub, LUB or, I and.
// The controller's state encodings are kept here so the bench and any tooling can name them.
package sterownik_alu_wielobajtowy_pkg;

  localparam logic [1:0] DODAJ   = 2'b00;
  localparam logic [1:0] ODEJMIJ = 2'b01;
  localparam logic [1:0] LUB     = 2'b10;
  localparam logic [1:0] I       = 2'b11;

  typedef enum logic [1:0] {
    BEZCZYNNY = 2'b00,
    LICZENIE  = 2'b01,
    GOTOWE    = 2'b10
  } stan_t;

  // Only add/sub propagate a carry/borrow between bytes and report C/OV.
  function automatic logic czy_arytmetyczna(input logic [1:0] wybor);
    return (wybor == DODAJ) || (wybor == ODEJMIJ);
  endfunction

endpackage

// File: rtl/sterownik_alu_wielobajtowy.sv
// Multi-byte initiator for the external 8-bit combinational ALU.
// Accepts an N-byte request (we_*), feeds the ALU one byte per cycle LSB first,
// chains carry/borrow through alu_p, and presents the N-byte result on wy_*.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   we_valid/we_ready           request handshake
//   we_wybor, we_a, we_b, we_p  operation, operands, carry/borrow-in
//   alu_a/b/wybor/p             drive to the ALU (zero outside LICZENIE)
//   alu_wynik/c/even/z/ov       combinational ALU response
//   wy_valid/wy_ready           result handshake
//   wy_wynik, wy_c/even/z/ov    registered result and flags
module sterownik_alu_wielobajtowy
  import sterownik_alu_wielobajtowy_pkg::*;
#(
  parameter int LICZBA_BAJTOW = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_valid,
  output logic                       we_ready,
  input  logic [1:0]                 we_wybor,
  input  logic [8*LICZBA_BAJTOW-1:0] we_a,
  input  logic [8*LICZBA_BAJTOW-1:0] we_b,
  input  logic                       we_p,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [1:0]                 alu_wybor,
  output logic                       alu_p,
  input  logic [7:0]                 alu_wynik,
  input  logic                       alu_c,
  input  logic                       alu_even,
  input  logic                       alu_z,
  input  logic                       alu_ov,
  output logic                       wy_valid,
  input  logic                       wy_ready,
  output logic [8*LICZBA_BAJTOW-1:0] wy_wynik,
  output logic                       wy_c,
  output logic                       wy_even,
  output logic                       wy_z,
  output logic                       wy_ov
);

  localparam int W  = 8 * LICZBA_BAJTOW;
  localparam int IW = (LICZBA_BAJTOW > 1) ? $clog2(LICZBA_BAJTOW) : 1;
  localparam logic [IW-1:0] OSTATNI = IW'(LICZBA_BAJTOW - 1);

  stan_t stan_reg, stan_next;

  logic [IW-1:0]                  indeks_reg;
  logic [LICZBA_BAJTOW-1:0][7:0]  a_reg;
  logic [LICZBA_BAJTOW-1:0][7:0]  b_reg;
  logic [LICZBA_BAJTOW-1:0][7:0]  wynik_reg;
  logic [LICZBA_BAJTOW-1:0][7:0]  wynik_pelny;
  logic [1:0]                     wybor_reg;
  logic                           lancuch_reg;   // carry/borrow into the current byte
  logic                           z_acc_reg;
  logic                           even_acc_reg;

  logic [W-1:0] wy_wynik_reg;
  logic         wy_c_reg;
  logic         wy_even_reg;
  logic         wy_z_reg;
  logic         wy_ov_reg;

  logic ostatni_bajt;
  assign ostatni_bajt = (indeks_reg == OSTATNI);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stan_reg <= BEZCZYNNY;
    end else begin
      stan_reg <= stan_next;
    end
  end

  // Next state and handshake/ALU drive
  always_comb begin
    stan_next = stan_reg;
    we_ready  = 1'b0;
    wy_valid  = 1'b0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_wybor = 2'b00;
    alu_p     = 1'b0;
    case (stan_reg)
      BEZCZYNNY: begin
        we_ready = 1'b1;
        if (we_valid) begin
          stan_next = LICZENIE;
        end
      end
      LICZENIE: begin
        alu_a     = a_reg[indeks_reg];
        alu_b     = b_reg[indeks_reg];
        alu_wybor = wybor_reg;
        // The chain register holds the ALU's C from the previous byte, which is
        // meaningless for or/and, so it is masked here rather than at capture.
        alu_p     = czy_arytmetyczna(wybor_reg) & lancuch_reg;
        if (ostatni_bajt) begin
          stan_next = GOTOWE;
        end
      end
      GOTOWE: begin
        wy_valid = 1'b1;
        if (wy_ready) begin
          stan_next = BEZCZYNNY;
        end
      end
      default: stan_next = BEZCZYNNY;
    endcase
  end

  // Result bytes including the one the ALU is producing this cycle.
  always_comb begin
    wynik_pelny             = wynik_reg;
    wynik_pelny[indeks_reg] = alu_wynik;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      indeks_reg   <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      wynik_reg    <= '0;
      wybor_reg    <= 2'b00;
      lancuch_reg  <= 1'b0;
      z_acc_reg    <= 1'b0;
      even_acc_reg <= 1'b0;
      wy_wynik_reg <= '0;
      wy_c_reg     <= 1'b0;
      wy_even_reg  <= 1'b0;
      wy_z_reg     <= 1'b0;
      wy_ov_reg    <= 1'b0;
    end else begin
      if ((stan_reg == BEZCZYNNY) && we_valid) begin
        a_reg        <= we_a;
        b_reg        <= we_b;
        wybor_reg    <= we_wybor;
        lancuch_reg  <= we_p;
        indeks_reg   <= '0;
        wynik_reg    <= '0;
        z_acc_reg    <= 1'b1;
        even_acc_reg <= 1'b0;
      end
      if (stan_reg == LICZENIE) begin
        wynik_reg    <= wynik_pelny;
        lancuch_reg  <= alu_c;
        z_acc_reg    <= z_acc_reg & alu_z;
        even_acc_reg <= even_acc_reg ^ alu_even;
        if (ostatni_bajt) begin
          // Outputs are loaded only here, on entry to GOTOWE.
          wy_wynik_reg <= wynik_pelny;
          wy_z_reg     <= z_acc_reg & alu_z;
          wy_even_reg  <= even_acc_reg ^ alu_even;
          wy_c_reg     <= czy_arytmetyczna(wybor_reg) & alu_c;
          wy_ov_reg    <= czy_arytmetyczna(wybor_reg) & alu_ov;
        end else begin
          indeks_reg <= indeks_reg + IW'(1);
        end
      end
    end
  end

  assign wy_wynik = wy_wynik_reg;
  assign wy_c     = wy_c_reg;
  assign wy_even  = wy_even_reg;
  assign wy_z     = wy_z_reg;
  assign wy_ov    = wy_ov_reg;

endmodule

// File: tb/tb_sterownik_alu_wielobajtowy.sv
// Bench for sterownik_alu_wielobajtowy with LICZBA_BAJTOW=2.
// Contains a behavioural 8-bit ALU wired to the alu_* ports, a whole-word
// reference model, directed cases and a randomized run.
module tb_sterownik_alu_wielobajtowy;

  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         we_valid = 1'b0;
  logic         we_ready;
  logic [1:0]   we_wybor = 2'b00;
  logic [W-1:0] we_a = '0;
  logic [W-1:0] we_b = '0;
  logic         we_p = 1'b0;
  logic [7:0]   alu_a, alu_b, alu_wynik;
  logic [1:0]   alu_wybor;
  logic         alu_p, alu_c, alu_even, alu_z, alu_ov;
  logic         wy_valid;
  logic         wy_ready = 1'b0;
  logic [W-1:0] wy_wynik;
  logic         wy_c, wy_even, wy_z, wy_ov;

  always #5 clk = ~clk;

  sterownik_alu_wielobajtowy #(.LICZBA_BAJTOW(N)) dut (
    .clk(clk), .rst(rst),
    .we_valid(we_valid), .we_ready(we_ready), .we_wybor(we_wybor),
    .we_a(we_a), .we_b(we_b), .we_p(we_p),
    .alu_a(alu_a), .alu_b(alu_b), .alu_wybor(alu_wybor), .alu_p(alu_p),
    .alu_wynik(alu_wynik), .alu_c(alu_c), .alu_even(alu_even),
    .alu_z(alu_z), .alu_ov(alu_ov),
    .wy_valid(wy_valid), .wy_ready(wy_ready), .wy_wynik(wy_wynik),
    .wy_c(wy_c), .wy_even(wy_even), .wy_z(wy_z), .wy_ov(wy_ov)
  );

  // Behavioural 8-bit ALU. For or/and it deliberately reports junk C/OV so the
  // controller's forcing of those flags is exercised.
  logic [8:0] alu_s;
  always_comb begin
    alu_s     = 9'h000;
    alu_wynik = 8'h00;
    alu_c     = 1'b0;
    alu_ov    = 1'b0;
    case (alu_wybor)
      2'b00: begin
        alu_s     = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_p};
        alu_wynik = alu_s[7:0];
        alu_c     = alu_s[8];
        alu_ov    = (alu_a[7] == alu_b[7]) && (alu_s[7] != alu_a[7]);
      end
      2'b01: begin
        alu_s     = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_p};
        alu_wynik = alu_s[7:0];
        alu_c     = alu_s[8];
        alu_ov    = (alu_a[7] != alu_b[7]) && (alu_s[7] != alu_a[7]);
      end
      2'b10: begin
        alu_wynik = alu_a | alu_b;
        alu_c     = alu_a[7];
        alu_ov    = alu_b[0];
      end
      default: begin
        alu_wynik = alu_a & alu_b;
        alu_c     = alu_a[0] | alu_b[7];
        alu_ov    = 1'b1;
      end
    endcase
    alu_z    = (alu_wynik == 8'h00);
    alu_even = ^alu_wynik;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic liczy = 1'b0;   // set while the bench expects the ALU to be driven
  logic [W-1:0] exp_wynik = '0;
  logic exp_c = 1'b0, exp_even = 1'b0, exp_z = 1'b0, exp_ov = 1'b0;

  task automatic sprawdz(input string nazwa, input logic [31:0] akt, input logic [31:0] ocz);
    n_cmp++;
    if (akt !== ocz) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nazwa, akt, ocz);
    end
  endtask

  // Whole-word reference: W-bit arithmetic, signed overflow from operand signs.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic p, output logic [W-1:0] wynik, output logic c,
                                output logic ov, output logic even, output logic z);
    logic [W:0] s;
    s  = '0;
    c  = 1'b0;
    ov = 1'b0;
    case (op)
      2'b00: begin
        s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, p};
        wynik = s[W-1:0];
        c     = s[W];
        ov    = (a[W-1] == b[W-1]) && (wynik[W-1] != a[W-1]);
      end
      2'b01: begin
        s     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, p};
        wynik = s[W-1:0];
        c     = s[W];
        ov    = (a[W-1] != b[W-1]) && (wynik[W-1] != a[W-1]);
      end
      2'b10:   wynik = a | b;
      default: wynik = a & b;
    endcase
    even = ^wynik;
    z    = (wynik == '0);
  endfunction

  // Carry/borrow entering byte k, from the low 8k bits of the operands.
  function automatic logic przen_do(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic p, input int k);
    logic [63:0] m, sa, sb;
    if (op[1]) return 1'b0;
    if (k == 0) return p;
    m  = (64'd1 << (8 * k)) - 64'd1;
    sa = 64'(a) & m;
    sb = 64'(b) & m;
    if (op == 2'b00) return ((sa + sb + 64'(p)) >> (8 * k)) != 64'd0;
    return sa < (sb + 64'(p));
  endfunction

  // Output checks on every cycle they are meaningful.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wy_valid === 1'b1) begin
        sprawdz("wy_wynik", 32'(wy_wynik), 32'(exp_wynik));
        sprawdz("wy_c", 32'(wy_c), 32'(exp_c));
        sprawdz("wy_even", 32'(wy_even), 32'(exp_even));
        sprawdz("wy_z", 32'(wy_z), 32'(exp_z));
        sprawdz("wy_ov", 32'(wy_ov), 32'(exp_ov));
      end
      if (!liczy) begin
        sprawdz("idle_alu_a", 32'(alu_a), 32'h0);
        sprawdz("idle_alu_b", 32'(alu_b), 32'h0);
        sprawdz("idle_alu_wybor", 32'(alu_wybor), 32'h0);
        sprawdz("idle_alu_p", 32'(alu_p), 32'h0);
      end
    end
  end

  // Issue a request and follow it byte by byte until wy_valid appears.
  // Called just after a falling edge.
  task automatic zadaj(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic p);
    int t;
    t = 0;
    while (we_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    sprawdz("we_ready_wait", 32'(we_ready), 32'h1);
    we_wybor = op; we_a = a; we_b = b; we_p = p; we_valid = 1'b1;
    model(op, a, b, p, exp_wynik, exp_c, exp_ov, exp_even, exp_z);
    @(posedge clk);
    liczy = 1'b1;
    #1;
    // Inputs must be ignored once latched.
    we_a = W'($urandom); we_b = W'($urandom); we_wybor = 2'($urandom);
    we_p = 1'($urandom); we_valid = 1'($urandom);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      sprawdz("alu_a", 32'(alu_a), 32'(a[8*k +: 8]));
      sprawdz("alu_b", 32'(alu_b), 32'(b[8*k +: 8]));
      sprawdz("alu_wybor", 32'(alu_wybor), 32'(op));
      sprawdz("alu_p", 32'(alu_p), 32'(przen_do(op, a, b, p, k)));
      sprawdz("busy_we_ready", 32'(we_ready), 32'h0);
      sprawdz("early_wy_valid", 32'(wy_valid), 32'h0);
      @(posedge clk);
    end
    liczy = 1'b0;
    @(negedge clk);
    we_valid = 1'b0;
    // A consumer sampling at the next rising edge sees valid N+1 edges after the handshake.
    sprawdz("latency_wy_valid", 32'(wy_valid), 32'h1);
  endtask

  // Hold backpressure for 'hold' cycles, then accept the result.
  task automatic odbierz(input int hold);
    for (int i = 0; i < hold; i++) begin
      wy_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      sprawdz("hold_wy_valid", 32'(wy_valid), 32'h1);
      sprawdz("hold_we_ready", 32'(we_ready), 32'h0);
    end
    wy_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wy_ready = 1'b0;
    sprawdz("release_wy_valid", 32'(wy_valid), 32'h0);
    sprawdz("release_we_ready", 32'(we_ready), 32'h1);
    $display("tx wynik=%h c=%0d even=%0d z=%0d ov=%0d hold=%0d", exp_wynik, exp_c, exp_even, exp_z, exp_ov, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mw;
    logic mc, mo, me, mz;
    logic [1:0] op;
    logic [W-1:0] ra, rb;
    logic [W-1:0] brzegi [4];

    brzegi[0] = 16'hFFFF; brzegi[1] = 16'h0000; brzegi[2] = 16'h8000; brzegi[3] = 16'h7FFF;

    #1 rst = 1'b1;
    #1;
    sprawdz("rst_we_ready", 32'(we_ready), 32'h1);
    sprawdz("rst_wy_valid", 32'(wy_valid), 32'h0);
    sprawdz("rst_wy_wynik", 32'(wy_wynik), 32'h0);
    sprawdz("rst_wy_flags", 32'({wy_c, wy_even, wy_z, wy_ov}), 32'h0);
    sprawdz("rst_alu", 32'({alu_a, alu_b, alu_wybor, alu_p}), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Hand-computed anchors for the reference model.
    model(2'b00, 16'h00FF, 16'h0001, 1'b0, mw, mc, mo, me, mz);
    sprawdz("model_add", 32'({mw, mc, mz, mo, me}), 32'({16'h0100, 1'b0, 1'b0, 1'b0, 1'b1}));
    model(2'b00, 16'hFFFF, 16'h0001, 1'b0, mw, mc, mo, me, mz);
    sprawdz("model_add_wrap", 32'({mw, mc, mz, mo, me}), 32'({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}));
    model(2'b01, 16'h0000, 16'h0001, 1'b0, mw, mc, mo, me, mz);
    sprawdz("model_sub_wrap", 32'({mw, mc, me}), 32'({16'hFFFF, 1'b1, 1'b0}));
    model(2'b11, 16'h1234, 16'h00FF, 1'b1, mw, mc, mo, me, mz);
    sprawdz("model_and", 32'({mw, mc, mz, mo, me}), 32'({16'h0034, 1'b0, 1'b0, 1'b0, 1'b1}));
    sprawdz("model_carry_byte1", 32'(przen_do(2'b00, 16'h00FF, 16'h0001, 1'b0, 1)), 32'h1);

    // Directed cases.
    zadaj(2'b00, 16'h00FF, 16'h0001, 1'b0); odbierz(0);
    zadaj(2'b00, 16'hFFFF, 16'h0001, 1'b0); odbierz(5);
    zadaj(2'b01, 16'h0100, 16'h0001, 1'b0); odbierz(1);
    zadaj(2'b01, 16'h0000, 16'h0001, 1'b0); odbierz(0);
    zadaj(2'b10, 16'h0F0F, 16'hF000, 1'b1); odbierz(0);
    zadaj(2'b11, 16'h1234, 16'h00FF, 1'b1); odbierz(2);
    zadaj(2'b00, 16'h7FFF, 16'h0001, 1'b0); odbierz(0);

    // Request presented while the result is being accepted: taken one cycle later.
    zadaj(2'b00, 16'h1111, 16'h2222, 1'b1);
    we_wybor = 2'b01; we_a = 16'hABCD; we_b = 16'h1234; we_p = 1'b1; we_valid = 1'b1;
    wy_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wy_ready = 1'b0;
    sprawdz("simul_still_idle", 32'(we_ready), 32'h1);
    sprawdz("simul_wy_valid", 32'(wy_valid), 32'h0);
    $display("tx wynik=%h c=%0d even=%0d z=%0d ov=%0d hold=0", exp_wynik, exp_c, exp_even, exp_z, exp_ov);
    zadaj(2'b01, 16'hABCD, 16'h1234, 1'b1); odbierz(0);

    // Reset while byte 1 is on the ALU.
    we_wybor = 2'b00; we_a = 16'h5A5A; we_b = 16'h1234; we_p = 1'b0; we_valid = 1'b1;
    @(posedge clk);
    liczy = 1'b1;
    #1 we_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    sprawdz("pre_rst_alu_a", 32'(alu_a), 32'h5A);
    #1 rst = 1'b1;
    liczy = 1'b0;
    #1;
    sprawdz("midrst_we_ready", 32'(we_ready), 32'h1);
    sprawdz("midrst_wy_valid", 32'(wy_valid), 32'h0);
    sprawdz("midrst_wy_wynik", 32'(wy_wynik), 32'h0);
    sprawdz("midrst_wy_flags", 32'({wy_c, wy_even, wy_z, wy_ov}), 32'h0);
    sprawdz("midrst_alu", 32'({alu_a, alu_b, alu_wybor, alu_p}), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sprawdz("postrst_we_ready", 32'(we_ready), 32'h1);
    sprawdz("postrst_wy_valid", 32'(wy_valid), 32'h0);
    zadaj(2'b00, 16'h0001, 16'h0001, 1'b0); odbierz(0);
    sprawdz("postrst_add_result", 32'(wy_wynik), 32'h0002);

    // Randomized run with some boundary operands.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = brzegi[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = brzegi[$urandom_range(0, 3)];
      zadaj(op, ra, rb, 1'($urandom));
      odbierz($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
